axis_upsize: RTL and testbench
==============================

// Module: axis_upsize
// PURPOSE
//  Single-clock AXI-Stream width upsizer: packs narrow beats into wide beats.
//  Reverse direction of the team's wide->narrow CDC downsizer path.
//  Sits on the return path where 32-bit streams feed the 64-bit datapath.
//  Preserves packet boundaries. A short final word is flagged per lane.
// PARAMETERS
//  WIDTH_P  32  input (narrow) data width, bits
//  WIDTH_S  64  output (wide) data width; WIDTH_S = RATIO*WIDTH_P, RATIO>=2 integer
// PORTS
//  clk           in   1        clock; single clock domain
//  rst_n         in   1        asynchronous, active-low reset
//  cfg           in   2        [0] lane order, [1] bypass; see CONFIGURATION
//  p_axis_data   in   WIDTH_P  narrow input data
//  p_axis_valid  in   1        input valid
//  p_axis_last   in   1        input end of packet
//  p_axis_ready  out  1        input ready
//  s_axis_data   out  WIDTH_S  wide output data
//  s_axis_lanes  out  RATIO    per-narrow-lane valid mask of the output word
//  s_axis_valid  out  1        output valid
//  s_axis_last   out  1        output end of packet
//  s_axis_ready  in   1        output ready
// BEHAVIOUR
//  - Reset (rst_n low): s_axis_valid=0, s_axis_last=0, s_axis_data=0,
//    s_axis_lanes=0, slot counter=0, accumulator cleared.
//  - p_axis_ready is forced 0 while rst_n is low.
//  - p_axis_ready = ~s_axis_valid | s_axis_ready after reset.
//  - Combinational ready path from s_axis_ready only. s_axis_* outputs are registered.
//  - Input beat accepted on p_axis_valid & p_axis_ready. It is written to slot cnt (0..RATIO-1).
//  - The beat completes a word when cnt==RATIO-1 or p_axis_last=1.
//  - Non-completing beat: stored in the accumulator, cnt++.
//  - Completing beat: the output register loads {beat, accumulator} the next cycle.
//  - On that load, s_axis_valid=1, s_axis_last=p_axis_last, lanes[i]=1 for i<=cnt, and cnt->0.
//  - Unfilled lanes are driven 0.
//  - Latency: completing beat accepted in cycle N -> s_axis_valid in cycle N+1.
//  - Throughput: one narrow beat per cycle sustained while s_axis_ready=1.
//  - Output hold: s_axis_valid stays 1 with stable data/lanes/last until s_axis_ready=1.
//  - Simultaneous out-handshake and completing-in: the output reloads the same cycle. There is no bubble.
//  - Last on slot 0: a one-lane word is emitted with last=1. No zero-length packets are possible.
//  - Reset mid-packet: the partial accumulator is discarded. No partial word is emitted.
//  - cfg is sampled on the first beat of each packet (cnt==0 and previous beat had last=1, or first beat after reset).
//  - cfg changes mid-packet are ignored until the next packet.
// CONFIGURATION
//  - cfg[0]=0: slot k occupies bits [k*WIDTH_P +: WIDTH_P] (first beat low).
//  - cfg[0]=1: slot k occupies lane RATIO-1-k (first beat high). lanes[] is mirrored the same way.
//  - cfg[1]=1 bypass: every beat completes a word on its own, in slot 0 only.
//    Lane placement and lanes[] follow cfg[0]. last is passed through.
//  - Optional macro AXIS_UPSIZE_STATS_EN:
//    - Defined: adds outputs o_word_cnt[15:0] and o_partial_cnt[15:0].
//    - o_word_cnt counts output handshakes; o_partial_cnt counts output handshakes with lanes != all-ones.
//    - Both counters wrap at 16'hFFFF->0 and reset to 0.
//    - Undefined: these ports and counters do not exist. Datapath behaviour is identical.
// STRUCTURE
//  - Package axis_width_pkg:
//    - RATIO calculation function.
//    - cfg_t packed struct {bypass, lane_order}.
//    - lane_order_e {LO_FIRST_LOW, LO_FIRST_HIGH}.
//    - Elaboration check that WIDTH_S % WIDTH_P == 0.
//  - Sub-module axis_upsize_acc: slot counter plus accumulator with lane mapping.
//    The top level holds the output register and the handshake.
// TESTING (WIDTH_P=32, WIDTH_S=64, s_axis_ready=1 unless noted)
//  1. cfg=0, beats 0x11111111, 0x22222222(last) -> one word 0x2222222211111111, lanes=2'b11, last=1.
//  2. cfg=0, beats A,B,C(last) with C=0x33333333 -> words {B,A} last=0, then 0x0000000033333333 lanes=2'b01 last=1.
//  3. cfg=1, beats 0xAAAAAAAA, 0xBBBBBBBB(last) -> 0xAAAAAAAABBBBBBBB, lanes=2'b11.
//  4. Back-pressure: s_axis_ready=0 for 5 cycles while a word is pending.
//     -> p_axis_ready=0, output held stable; resume yields no loss or duplication. 1000-beat random stream vs model.
//  5. cfg=2 bypass, beats 0x5, 0x6(last) -> 0x0000000000000005 and 0x0000000000000006, lanes=2'b01 each.
//  6. rst_n pulsed low after 1 beat of a packet -> s_axis_valid=0, next packet packs from slot 0.
//     With AXIS_UPSIZE_STATS_EN: counters=0 after reset; test 2 gives word=2, partial=1.

Source files
------------

// File: rtl/axis_width_pkg.sv
// Shared types and width helpers for the AXI-Stream width converters.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axis_width_pkg;

    typedef enum logic {
        LO_FIRST_LOW  = 1'b0,
        LO_FIRST_HIGH = 1'b1
    } lane_order_e;

    // Field order matches the cfg port: [1] bypass, [0] lane order.
    typedef struct packed {
        logic        bypass;
        lane_order_e lane_order;
    } cfg_t;

    // Number of narrow lanes packed into one wide word.
    function automatic int calc_ratio(input int width_p, input int width_s);
        return width_s / width_p;
    endfunction

    // Wide width must be a whole multiple (at least two) of the narrow width.
    function automatic bit width_ok(input int width_p, input int width_s);
        return (width_p > 0) && (width_s % width_p == 0) && (width_s / width_p >= 2);
    endfunction

endpackage

// File: rtl/axis_upsize_acc.sv
// Slot counter and lane-mapped accumulator; presents the completed wide word combinationally.
// Latency: 0 cycles from an accepted completing beat to word_done/word_dat.
// Backpressure: none of its own; beat_vld must only pulse on an accepted input beat.
module axis_upsize_acc
    import axis_width_pkg::*;
#(
    parameter int WIDTH_P = 32,
    parameter int WIDTH_S = 64,
    localparam int RATIO  = calc_ratio(WIDTH_P, WIDTH_S),
    localparam int CW     = $clog2(RATIO)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg,
    input  logic               beat_vld,
    input  logic [WIDTH_P-1:0] beat_dat,
    input  logic               beat_last,
    output logic               word_done,
    output logic [WIDTH_S-1:0] word_dat,
    output logic [RATIO-1:0]   word_lanes
);

    logic [CW-1:0]      cnt_q;
    logic [WIDTH_S-1:0] acc_q;
    logic               sop_q;
    cfg_t               cfg_q;
    cfg_t               cfg_cur;
    logic [CW-1:0]      lane;
    logic [RATIO-1:0]   slot_mask;

    // cfg is taken live on the first beat of a packet, then frozen until the packet ends.
    assign cfg_cur = sop_q ? cfg_t'(cfg) : cfg_q;

    // Merge the current beat into its lane and build the per-lane valid mask.
    always_comb begin
        word_done  = cfg_cur.bypass || beat_last || (cnt_q == CW'(RATIO - 1));
        lane       = (cfg_cur.lane_order == LO_FIRST_HIGH) ? (CW'(RATIO - 1) - cnt_q) : cnt_q;
        word_dat   = acc_q;
        slot_mask  = '0;
        word_lanes = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == i[CW-1:0]) begin
                word_dat[i*WIDTH_P +: WIDTH_P] = beat_dat;
            end
            slot_mask[i] = (i[CW-1:0] <= cnt_q);
        end
        for (int i = 0; i < RATIO; i++) begin
            word_lanes[i] = (cfg_cur.lane_order == LO_FIRST_HIGH) ? slot_mask[RATIO-1-i] : slot_mask[i];
        end
    end

    // Advance the slot on partial beats; clear everything once a word completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            sop_q <= 1'b1;
            cfg_q <= '0;
        end else if (beat_vld) begin
            if (sop_q) begin
                cfg_q <= cfg_cur;
            end
            sop_q <= beat_last;
            if (word_done) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= word_dat;
            end
        end
    end

endmodule

// File: rtl/axis_upsize.sv
// AXI-Stream narrow->wide packer with per-lane valid mask; AXIS_UPSIZE_STATS_EN adds word/partial counters.
// Latency: completing narrow beat accepted in cycle N gives s_axis_valid in cycle N+1.
// Backpressure: p_axis_ready = ~s_axis_valid | s_axis_ready (held low in reset); output held until taken.
module axis_upsize
    import axis_width_pkg::*;
#(
    parameter int WIDTH_P = 32,
    parameter int WIDTH_S = 64,
    localparam int RATIO  = calc_ratio(WIDTH_P, WIDTH_S)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg,
    input  logic [WIDTH_P-1:0] p_axis_data,
    input  logic               p_axis_valid,
    input  logic               p_axis_last,
    output logic               p_axis_ready,
    output logic [WIDTH_S-1:0] s_axis_data,
    output logic [RATIO-1:0]   s_axis_lanes,
    output logic               s_axis_valid,
    output logic               s_axis_last,
    input  logic               s_axis_ready
`ifdef AXIS_UPSIZE_STATS_EN
    ,
    output logic [15:0]        o_word_cnt,
    output logic [15:0]        o_partial_cnt
`endif
);

    if (!width_ok(WIDTH_P, WIDTH_S)) begin : g_bad_width
        $error("axis_upsize: WIDTH_S must be an integer multiple (>=2) of WIDTH_P");
    end

    logic               p_fire;
    logic               word_done;
    logic [WIDTH_S-1:0] word_dat;
    logic [RATIO-1:0]   word_lanes;

    assign p_axis_ready = rst_n & (~s_axis_valid | s_axis_ready);
    assign p_fire       = p_axis_valid & p_axis_ready;

    axis_upsize_acc #(
        .WIDTH_P (WIDTH_P),
        .WIDTH_S (WIDTH_S)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg),
        .beat_vld   (p_fire),
        .beat_dat   (p_axis_data),
        .beat_last  (p_axis_last),
        .word_done  (word_done),
        .word_dat   (word_dat),
        .word_lanes (word_lanes)
    );

    // Output register: reload on a completing beat (even while draining), else clear valid once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axis_valid <= 1'b0;
            s_axis_last  <= 1'b0;
            s_axis_data  <= '0;
            s_axis_lanes <= '0;
        end else if (p_fire && word_done) begin
            s_axis_valid <= 1'b1;
            s_axis_last  <= p_axis_last;
            s_axis_data  <= word_dat;
            s_axis_lanes <= word_lanes;
        end else if (s_axis_ready) begin
            s_axis_valid <= 1'b0;
        end
    end

`ifdef AXIS_UPSIZE_STATS_EN
    logic s_fire;
    assign s_fire = s_axis_valid & s_axis_ready;

    // Count delivered words and those with at least one empty lane; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_word_cnt    <= '0;
            o_partial_cnt <= '0;
        end else if (s_fire) begin
            o_word_cnt <= o_word_cnt + 16'd1;
            if (s_axis_lanes != '1) begin
                o_partial_cnt <= o_partial_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_upsize.sv
// Directed bench for axis_upsize at 32->64 bits, plus a random-stream scoreboard.
// Latency: n/a.
// Backpressure: exercised via held and randomised s_axis_ready.
module tb_axis_upsize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cfg = 2'b00;
    logic [31:0] p_axis_data = '0;
    logic        p_axis_valid = 1'b0;
    logic        p_axis_last = 1'b0;
    logic        p_axis_ready;
    logic [63:0] s_axis_data;
    logic [1:0]  s_axis_lanes;
    logic        s_axis_valid;
    logic        s_axis_last;
    logic        s_axis_ready;
    logic        rdy_man = 1'b1;
    logic        rdy_rnd = 1'b1;
    logic        tog_en = 1'b0;
`ifdef AXIS_UPSIZE_STATS_EN
    logic [15:0] o_word_cnt;
    logic [15:0] o_partial_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // {lanes, last, data} of each output handshake, in order
    logic [66:0] out_q[$];
    logic [66:0] exp_q[$];

    assign s_axis_ready = tog_en ? rdy_rnd : rdy_man;

    axis_upsize #(.WIDTH_P(32), .WIDTH_S(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg),
        .p_axis_data  (p_axis_data),
        .p_axis_valid (p_axis_valid),
        .p_axis_last  (p_axis_last),
        .p_axis_ready (p_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_lanes (s_axis_lanes),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready)
`ifdef AXIS_UPSIZE_STATS_EN
        ,
        .o_word_cnt    (o_word_cnt),
        .o_partial_cnt (o_partial_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Record output handshakes mid-cycle, where all inputs are settled.
    always @(negedge clk) begin
        if (rst_n && s_axis_valid && s_axis_ready) begin
            out_q.push_back({s_axis_lanes, s_axis_last, s_axis_data});
        end
    end

    // Random sink readiness for the streaming test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rnd = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_axis_valid = 1'b0;
        p_axis_last  = 1'b0;
    endtask

    // Present one beat and return #1 after the edge that accepts it.
    task automatic send(input logic [31:0] d, input logic l);
        int budget;
        p_axis_valid = 1'b1;
        p_axis_data  = d;
        p_axis_last  = l;
        budget = 0;
        @(negedge clk);
        while (!p_axis_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!p_axis_ready) chk("send_rdy", p_axis_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [63:0] d, input logic [1:0] ln, input logic l);
        logic [66:0] w;
        chk({tag, "_present"}, (out_q.size() > 0), 1);
        if (out_q.size() > 0) begin
            w = out_q.pop_front();
            chk({tag, "_data"}, w[63:0], d);
            chk({tag, "_lanes"}, w[66:65], ln);
            chk({tag, "_last"}, w[64], l);
        end
    endtask

    initial begin
        logic [63:0] acc;
        logic [31:0] d;
        logic        l;
        int          slot;
        int          n;

        // Reset state, with the sink ready so p_axis_ready must be forced low by reset
        repeat (2) @(negedge clk);
        chk("rst_valid", s_axis_valid, 0);
        chk("rst_last", s_axis_last, 0);
        chk("rst_data", s_axis_data, 0);
        chk("rst_lanes", s_axis_lanes, 0);
        chk("rst_p_ready", p_axis_ready, 0);
`ifdef AXIS_UPSIZE_STATS_EN
        chk("rst_word_cnt", o_word_cnt, 0);
        chk("rst_partial_cnt", o_partial_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(1);
        chk("p_ready_after_rst", p_axis_ready, 1);

        // Three-beat packet: one full word, then a short final word
        cfg = 2'b00;
        send(32'hA0A0A0A0, 1'b0);
        send(32'hB0B0B0B0, 1'b0);
        send(32'h33333333, 1'b1);
        idle();
        wait_cycles(4);
        expect_word("t2_w0", 64'hB0B0B0B0A0A0A0A0, 2'b11, 1'b0);
        expect_word("t2_w1", 64'h0000000033333333, 2'b01, 1'b1);
`ifdef AXIS_UPSIZE_STATS_EN
        chk("t2_word_cnt", o_word_cnt, 2);
        chk("t2_partial_cnt", o_partial_cnt, 1);
`endif

        // Two-beat packet, first beat low; valid one cycle after the completing beat
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b1);
        chk("t1_latency", s_axis_valid, 1);
        idle();
        wait_cycles(3);
        expect_word("t1", 64'h2222222211111111, 2'b11, 1'b1);

        // First beat high
        cfg = 2'b01;
        send(32'hAAAAAAAA, 1'b0);
        send(32'hBBBBBBBB, 1'b1);
        send(32'h12345678, 1'b1);
        idle();
        wait_cycles(4);
        expect_word("t3", 64'hAAAAAAAABBBBBBBB, 2'b11, 1'b1);
        expect_word("t3_short", 64'h1234567800000000, 2'b10, 1'b1);

        // Bypass: one beat per word, slot 0 only
        cfg = 2'b10;
        send(32'h00000005, 1'b0);
        send(32'h00000006, 1'b1);
        cfg = 2'b11;
        send(32'h00000007, 1'b1);
        idle();
        wait_cycles(4);
        expect_word("t5_a", 64'h0000000000000005, 2'b01, 1'b0);
        expect_word("t5_b", 64'h0000000000000006, 2'b01, 1'b1);
        expect_word("t5_hi", 64'h0000000700000000, 2'b10, 1'b1);

        // cfg change inside a packet is ignored until the next packet
        cfg = 2'b00;
        send(32'h00000001, 1'b0);
        cfg = 2'b01;
        send(32'h00000002, 1'b1);
        cfg = 2'b00;
        idle();
        wait_cycles(3);
        expect_word("cfg_mid", 64'h0000000200000001, 2'b11, 1'b1);

        // Back-pressure: pending word held stable, input stalled
        rdy_man = 1'b0;
        send(32'h0F0F0F0F, 1'b0);
        send(32'hF0F0F0F0, 1'b1);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_p_ready", p_axis_ready, 0);
            chk("bp_valid", s_axis_valid, 1);
            chk("bp_data", s_axis_data, 64'hF0F0F0F00F0F0F0F);
        end
        @(posedge clk);
        #1;
        rdy_man = 1'b1;
        wait_cycles(3);
        expect_word("bp_resume", 64'hF0F0F0F00F0F0F0F, 2'b11, 1'b1);
        chk("bp_no_dup", out_q.size(), 0);

        // Random stream under random sink stalls, checked against a packing model
        cfg = 2'b00;
        tog_en = 1'b1;
        acc = '0;
        slot = 0;
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            l = (i == 999) || ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                wait_cycles(1);
            end
            send(d, l);
            acc[slot*32 +: 32] = d;
            if (slot == 1 || l) begin
                exp_q.push_back({(slot == 1) ? 2'b11 : 2'b01, l, acc});
                acc = '0;
                slot = 0;
            end else begin
                slot = 1;
            end
        end
        idle();
        tog_en = 1'b0;
        wait_cycles(6);
        chk("rand_count", out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("rand_data", out_q[i][63:0], exp_q[i][63:0]);
            chk("rand_ctl", out_q[i][66:64], exp_q[i][66:64]);
        end
        out_q.delete();
        exp_q.delete();

        // Reset mid-packet discards the partial word
        send(32'hDEAD0001, 1'b0);
        idle();
        wait_cycles(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", s_axis_valid, 0);
        chk("mid_rst_p_ready", p_axis_ready, 0);
`ifdef AXIS_UPSIZE_STATS_EN
        chk("mid_rst_word_cnt", o_word_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(2);
        chk("mid_rst_no_word", out_q.size(), 0);
        send(32'h44444444, 1'b0);
        send(32'h55555555, 1'b1);
        idle();
        wait_cycles(3);
        expect_word("post_rst", 64'h5555555544444444, 2'b11, 1'b1);
        chk("post_rst_count", out_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
